// File: rtl/seq_div_reconstruct16.sv
// Rebuilds a divider's dividend as lop = quot * rop + mod using a radix-2
// shift-add loop, one multiplier bit per clock, with valid/ready on both sides.
module seq_div_reconstruct16 #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_WIDTH-1:0]     quot,
    input  logic [WORD_WIDTH-1:0]     rop,
    input  logic [WORD_WIDTH-1:0]     mod,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*WORD_WIDTH-1:0]   lop,
    output logic                      ovf
);
    localparam int CW = $clog2(WORD_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                    state, state_nxt;
    logic [2*WORD_WIDTH-1:0]   acc, acc_nxt, acc_sum;
    logic [2*WORD_WIDTH-1:0]   mcand, mcand_nxt;
    logic [WORD_WIDTH-1:0]     mplier, mplier_nxt;
    logic [CW-1:0]             cnt, cnt_nxt;
    logic                      in_ready_nxt, out_valid_nxt, ovf_nxt;
    logic [2*WORD_WIDTH-1:0]   lop_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            lop       <= '0;
            ovf       <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            lop       <= lop_nxt;
            ovf       <= ovf_nxt;
            acc       <= acc_nxt;
            mcand     <= mcand_nxt;
            mplier    <= mplier_nxt;
            cnt       <= cnt_nxt;
        end
    end

    // The 2W-bit sum cannot truncate: the largest result is 2^(2W) - 2^W.
    assign acc_sum = mplier[0] ? (acc + mcand) : acc;

    always_comb begin
        state_nxt     = state;
        out_valid_nxt = out_valid;
        lop_nxt       = lop;
        ovf_nxt       = ovf;
        acc_nxt       = acc;
        mcand_nxt     = mcand;
        mplier_nxt    = mplier;
        cnt_nxt       = cnt;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    acc_nxt    = {{WORD_WIDTH{1'b0}}, mod};
                    mcand_nxt  = {{WORD_WIDTH{1'b0}}, rop};
                    mplier_nxt = quot;
                    cnt_nxt    = '0;
                    state_nxt  = CALC;
                end
            end
            CALC: begin
                acc_nxt    = acc_sum;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + CW'(1);
                // Always runs the full WORD_WIDTH steps so latency is fixed.
                if (cnt == LAST) begin
                    state_nxt     = DONE;
                    lop_nxt       = acc_sum;
                    ovf_nxt       = |acc_sum[2*WORD_WIDTH-1:WORD_WIDTH];
                    out_valid_nxt = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        in_ready_nxt = (state_nxt == IDLE);
    end
endmodule

// File: tb/tb_seq_div_reconstruct16.sv
// Directed bench for seq_div_reconstruct16: stimulus pushes expected results
// into a scoreboard queue; a monitor pops and compares on each output handshake.
module tb_seq_div_reconstruct16;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] quot = '0, rop = '0, mod = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] lop;
    logic        ovf;

    typedef struct {logic [31:0] lop; logic ovf;} exp_t;
    exp_t sb[$];

    int total = 0;
    int passed = 0;

    seq_div_reconstruct16 #(.WORD_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .quot(quot), .rop(rop), .mod(mod),
        .out_valid(out_valid), .out_ready(out_ready),
        .lop(lop), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: one pop per output handshake.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_result: got lop=0x%0h with no result outstanding", lop);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_lop", lop, e.lop);
                check("result_ovf", {31'b0, ovf}, {31'b0, e.ovf});
            end
        end
    end

    // Present operands and wait for the accepting edge; returns #1 after it.
    task automatic accept(input logic [15:0] q, input logic [15:0] r, input logic [15:0] m,
                          input logic [31:0] exp_lop, input logic exp_ovf);
        int n;
        exp_t e;
        quot = q; rop = r; mod = m; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) begin
            total++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1");
        end
        e.lop = exp_lop; e.ovf = exp_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Count edges from acceptance until out_valid appears.
    task automatic wait_latency(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 40);
        check(name, n, 16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        #2;
        check("rst_in_ready", {31'b0, in_ready}, 0);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_lop", lop, 0);
        check("rst_ovf", {31'b0, ovf}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", {31'b0, in_ready}, 1);

        // 1: simple op, latency and in_ready return
        accept(16'd1, 16'd3, 16'd2, 32'd5, 1'b0);
        in_valid = 1'b0;
        check("t1_in_ready_drop", {31'b0, in_ready}, 0);
        wait_latency("t1_latency");
        @(posedge clk); #1;
        check("t1_out_valid_clear", {31'b0, out_valid}, 0);
        check("t1_in_ready_back", {31'b0, in_ready}, 1);

        // 2: back-to-back with in_valid held high
        accept(16'd3, 16'd13, 16'd6, 32'd45, 1'b0);
        quot = 16'd4; rop = 16'd5; mod = 16'd0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!in_ready && n < 40);
        check("t2_second_accept_gap", n, 17);
        check("t2_first_done", {31'b0, out_valid}, 0);
        begin
            exp_t e;
            e.lop = 32'd20; e.ovf = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t2_second_accepted", {31'b0, in_ready}, 0);
        wait_latency("t2_latency");
        @(posedge clk); #1;

        // 3: maximum operands, then zero divisor
        accept(16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF0000, 1'b1);
        in_valid = 1'b0;
        wait_latency("t3_max_latency");
        @(posedge clk); #1;
        accept(16'h1234, 16'h0000, 16'h0007, 32'h00000007, 1'b0);
        in_valid = 1'b0;
        wait_latency("t3_rop0_latency");
        @(posedge clk); #1;

        // 4: backpressure for 5 cycles
        out_ready = 1'b0;
        accept(16'd7, 16'd9, 16'd4, 32'd67, 1'b0);
        in_valid = 1'b0;
        wait_latency("t4_latency");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t4_hold_valid", {31'b0, out_valid}, 1);
            check("t4_hold_lop", lop, 32'd67);
            check("t4_hold_in_ready", {31'b0, in_ready}, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_release_valid", {31'b0, out_valid}, 0);
        check("t4_release_in_ready", {31'b0, in_ready}, 1);

        // 5: inputs (and in_valid) wiggle during CALC
        accept(16'd10, 16'd10, 16'd3, 32'd103, 1'b0);
        for (int i = 0; i < 12; i++) begin
            quot = 16'(16'h1111 * (i + 1)); rop = 16'(16'h0F0F + i); mod = 16'(16'h00A5 ^ i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("t5_done_edge", n, 4);
        @(posedge clk); #1;

        // 6: reset pulse mid-CALC
        accept(16'd5, 16'd5, 16'd5, 32'd30, 1'b0);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_rst_out_valid", {31'b0, out_valid}, 0);
        check("t6_rst_lop", lop, 0);
        check("t6_rst_in_ready", {31'b0, in_ready}, 0);
        sb.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("t6_in_ready_release", {31'b0, in_ready}, 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        check("t6_no_stale", n, 0);
        accept(16'd2, 16'd8, 16'd1, 32'd17, 1'b0);
        in_valid = 1'b0;
        wait_latency("t6_latency");
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/seq_div_reconstruct16.md
Name: seq_div_reconstruct16

Overview:
- Sequential inverse of the 16-bit combinational divider: rebuilds the dividend from a divider result, lop = quot * rop + mod.
- Uses a radix-2 shift-add datapath, one multiplier bit per clock, with valid/ready handshakes on both sides.
- Sits downstream of the divider in the redundancy datapath to cross-check divider results, or to regenerate operands.

Parameters:
WORD_WIDTH, 16, width of quot, rop and mod; the result is 2*WORD_WIDTH wide.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept an operand set
quot  input  WORD_WIDTH  quotient (multiplier)
rop  input  WORD_WIDTH  divisor (multiplicand)
mod  input  WORD_WIDTH  remainder (addend)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
lop  output  2*WORD_WIDTH  reconstructed dividend, quot*rop+mod
ovf  output  1  high when lop[2*WORD_WIDTH-1:WORD_WIDTH] is non-zero

Behaviour:
- Clock and reset: one clock domain, clk. reset_n is asynchronous and active-low.
- Reset (reset_n low): all flops clear immediately.
  - state=IDLE, in_ready=0, out_valid=0, lop=0, ovf=0.
  - Internal acc, mcand, mplier and cnt=0.
- in_ready is registered. It goes to 1 on the first rising edge after reset_n deasserts. Thereafter it is 1 exactly when state==IDLE.
- States: IDLE, CALC, DONE.
- IDLE:
  - Accept on a rising edge with in_valid && in_ready.
  - Load acc = {WORD_WIDTH'b0, mod}, mcand = {WORD_WIDTH'b0, rop}, mplier = quot, cnt = 0.
  - Go to CALC; in_ready drops on the same edge.
  - Operands are sampled only at acceptance; later input changes are ignored.
- CALC, on each edge:
  - If mplier[0], then acc = acc + mcand, modulo 2^(2W).
  - mcand <<= 1, mplier >>= 1, cnt += 1.
  - After the WORD_WIDTH-th CALC edge, go to DONE.
  - lop <= final acc, ovf <= |final_acc[2W-1:W], out_valid <= 1, all on that same edge.
- Latency and throughput:
  - Fixed latency: out_valid rises WORD_WIDTH edges after the accepting edge. There is no early termination, even for quot=0.
  - Throughput is one operation per WORD_WIDTH+2 cycles minimum.
- DONE:
  - lop, ovf and out_valid hold stable while out_ready=0, for unbounded backpressure.
  - On an edge with out_ready=1: out_valid <= 0, state <= IDLE, in_ready <= 1.
  - The next acceptance occurs no earlier than the following edge.
- Arithmetic:
  - All values are unsigned.
  - The maximum result, (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, fits in 2W bits, so no truncation occurs.
  - ovf flags only that the result exceeds WORD_WIDTH bits. A consistent divider result (mod < rop) from a WORD_WIDTH-bit dividend never sets ovf.
- Boundary cases:
  - rop=0 gives lop=mod.
  - quot=0 gives lop=mod.
  - mod=0 gives a pure product.
- Reset asserted mid-CALC or mid-DONE:
  - The operation is abandoned and outputs clear immediately.
  - No result is produced after release.
- in_valid while not in IDLE is ignored; the operand is not queued.
- out_ready while out_valid=0 has no effect.

Test Plan:
1. quot=1, rop=3, mod=2, out_ready=1 -> out_valid rises exactly 16 edges after acceptance; lop=5, ovf=0; in_ready returns 1 one edge after the output handshake.
2. Back-to-back sets (3,13,6) then (4,5,0), in_valid held high -> lop=45, then lop=20. Each result appears once, and the second acceptance occurs only after the first output handshake.
3. quot=0xFFFF, rop=0xFFFF, mod=0xFFFF -> lop=0xFFFF0000, ovf=1. Then quot=0x1234, rop=0, mod=0x0007 -> lop=0x00000007, ovf=0, latency still 16.
4. quot=7, rop=9, mod=4 with out_ready=0 for 5 cycles after out_valid rises -> lop=67 and out_valid stay stable throughout and in_ready stays 0. The handshake completes on the first edge with out_ready=1.
5. Change quot, rop and mod every cycle during CALC after accepting (10,10,3) -> lop=103, i.e. only the accepted operands are used.
6. Pulse reset_n low for 1 cycle 8 edges into CALC -> out_valid=0 and lop=0 immediately; in_ready=1 one edge after release. No stale result appears, and a fresh (2,8,1) then yields lop=17.
